// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO filled at clk rate, drained
// back-to-back by a bit-serial engine with a registered line output.
module uart_tx_buffered #(
    parameter int CLOCK      = 25000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_byte,
    input  logic                          tx_write,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          tx_overflow,
    output logic                          tx_busy,
    output logic                          tx_pin
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CPB = CLOCK / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] lvl_nxt;
    logic          push, pop;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          pin_nxt;
    logic          bit_end;

    // Writes are judged against the registered full flag, so a pop on the
    // same edge never rescues a write that arrives while full.
    assign push    = tx_write && !tx_full;
    assign bit_end = (cnt == CW'(CPB - 1));
    assign tx_busy = (state != IDLE) || !tx_empty;

    always_comb begin
        lvl_nxt = tx_level;
        case ({push, pop})
            2'b10:   lvl_nxt = tx_level + LW'(1);
            2'b01:   lvl_nxt = tx_level - LW'(1);
            default: lvl_nxt = tx_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_level    <= '0;
            tx_full     <= 1'b0;
            tx_empty    <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            tx_level    <= lvl_nxt;
            tx_full     <= (lvl_nxt == LW'(FIFO_DEPTH));
            tx_empty    <= (lvl_nxt == '0);
            tx_overflow <= tx_write && tx_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            tx_pin <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            tx_pin <= pin_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        pin_nxt   = tx_pin;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                pin_nxt = 1'b1;
                if (!tx_empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    cnt_nxt   = '0;
                    state_nxt = START;
                    pin_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                    pin_nxt   = shift[0];
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                        pin_nxt   = 1'b1;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                        pin_nxt   = shift[1];
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!tx_empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                        pin_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        pin_nxt   = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 10 clk/bit with a line decoder
// that collects received bytes and their start-bit times.
module tb_uart_tx_buffered;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = '0;
    logic       tx_write = 1'b0;
    logic       tx_full, tx_empty, tx_overflow, tx_busy, tx_pin;
    logic [4:0] tx_level;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    bit mon_en = 1'b1;
    logic [7:0] rx_q[$];
    int         st_q[$];

    uart_tx_buffered #(.CLOCK(1000000), .BAUD(100000), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte), .tx_write(tx_write),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
        .tx_overflow(tx_overflow), .tx_busy(tx_busy), .tx_pin(tx_pin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_overflow === 1'b1) ovf_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (tx_busy !== 1'b0 && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, tx_busy, 1'b0);
    endtask

    task automatic check_rx(input logic [7:0] exp[$], input bit contig, input string tag);
        chk({tag, "_count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
        if (contig)
            for (int i = 1; i < st_q.size(); i++)
                chk($sformatf("%s_gap%0d", tag, i), st_q[i] - st_q[i-1], 100);
        rx_q.delete();
        st_q.delete();
    endtask

    // Line decoder: mid-bit sampling 5 cycles into each 10-cycle bit.
    initial begin : mon
        logic [7:0] b;
        logic       sb;
        int         t0;
        b = '0;
        forever begin
            step();
            if (rst_n === 1'b1 && tx_pin === 1'b0) begin
                t0 = cyc;
                repeat (5) @(posedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (10) @(posedge clk);
                    #1;
                    b[k] = tx_pin;
                end
                repeat (10) @(posedge clk);
                #1;
                sb = tx_pin;
                if (mon_en) begin
                    chk("stop_bit", sb, 1'b1);
                    rx_q.push_back(b);
                    st_q.push_back(t0);
                end
            end
        end
    end

    initial begin : main
        logic [7:0] exp[$];
        logic [9:0] frame;
        int t1, ovf0, lvl_max, lows;

        // reset values
        repeat (3) step();
        chk("rst_pin", tx_pin, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_empty", tx_empty, 1'b1);
        chk("rst_full", tx_full, 1'b0);
        chk("rst_level", tx_level, 5'd0);
        chk("rst_ovf", tx_overflow, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: single 0xA5, latency and bit pattern
        tx_write = 1'b1; tx_byte = 8'hA5;
        step();
        tx_write = 1'b0;
        chk("t1_pin_e0", tx_pin, 1'b1);
        chk("t1_busy_e0", tx_busy, 1'b1);
        chk("t1_level_e0", tx_level, 5'd1);
        step();
        chk("t1_pin_fall", tx_pin, 1'b0);
        chk("t1_level_e1", tx_level, 5'd0);
        chk("t1_empty_e1", tx_empty, 1'b1);
        frame = 10'b1_1010_0101_0;
        for (int k = 0; k < 10; k++) begin
            repeat (k == 0 ? 5 : 10) step();
            chk($sformatf("t1_bit%0d", k), tx_pin, frame[k]);
        end
        repeat (4) step();
        chk("t1_busy_99", tx_busy, 1'b1);
        step();
        chk("t1_busy_100", tx_busy, 1'b0);
        chk("t1_pin_100", tx_pin, 1'b1);
        exp = '{8'hA5};
        check_rx(exp, 1'b0, "t1_rx");

        // 2: 18 back-to-back writes from idle; one pops, 16 fill, last dropped
        ovf0 = ovf_cnt; lvl_max = 0; t1 = 0;
        for (int i = 0; i < 18; i++) begin
            tx_write = 1'b1; tx_byte = 8'(i);
            step();
            if (i == 1) t1 = cyc;
            if (int'(tx_level) > lvl_max) lvl_max = int'(tx_level);
        end
        tx_write = 1'b0;
        chk("t2_level", tx_level, 5'd16);
        chk("t2_full", tx_full, 1'b1);
        chk("t2_peak", lvl_max, 16);
        repeat (3) step();
        chk("t2_ovf_pulses", ovf_cnt - ovf0, 1);

        // 3: write while full on the exact pop edge is dropped
        wait_cyc(t1 + 99);
        tx_write = 1'b1; tx_byte = 8'hEE;
        step();
        tx_write = 1'b0;
        chk("t3_ovf", tx_overflow, 1'b1);
        chk("t3_level", tx_level, 5'd15);
        chk("t3_full", tx_full, 1'b0);
        chk("t3_pin_start", tx_pin, 1'b0);
        step();
        chk("t3_ovf_clear", tx_overflow, 1'b0);
        wait_idle(2000, "t2_idle");
        exp.delete();
        for (int i = 0; i < 17; i++) exp.push_back(8'(i));
        check_rx(exp, 1'b1, "t2_rx");

        // 4: level 1, write on the pop edge keeps the level and the frames contiguous
        tx_write = 1'b1; tx_byte = 8'h3C;
        step();
        tx_byte = 8'h5A;
        step();
        t1 = cyc;
        tx_write = 1'b0;
        chk("t4_level_a", tx_level, 5'd1);
        chk("t4_pin_a", tx_pin, 1'b0);
        wait_cyc(t1 + 99);
        tx_write = 1'b1; tx_byte = 8'h96;
        step();
        tx_write = 1'b0;
        chk("t4_level_pop", tx_level, 5'd1);
        chk("t4_pin_pop", tx_pin, 1'b0);
        wait_idle(400, "t4_idle");
        exp = '{8'h3C, 8'h5A, 8'h96};
        check_rx(exp, 1'b1, "t4_rx");

        // 5: async reset in DATA bit 3 with 5 bytes queued
        mon_en = 1'b0;
        t1 = 0;
        for (int i = 0; i < 6; i++) begin
            tx_write = 1'b1; tx_byte = 8'(8'h11 * (i + 1));
            step();
            if (i == 1) t1 = cyc;
        end
        tx_write = 1'b0;
        chk("t5_level", tx_level, 5'd5);
        wait_cyc(t1 + 45);
        chk("t5_bit3", tx_pin, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_pin", tx_pin, 1'b1);
        chk("t5_busy", tx_busy, 1'b0);
        chk("t5_empty", tx_empty, 1'b1);
        chk("t5_full", tx_full, 1'b0);
        chk("t5_level0", tx_level, 5'd0);
        chk("t5_ovf", tx_overflow, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            step();
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("t5_quiet", lows, 0);
        rx_q.delete();
        st_q.delete();
        mon_en = 1'b1;

        // 6: 6 bursts of 8 spaced 800 cycles; pointers wrap 3 times
        ovf0 = ovf_cnt;
        exp.delete();
        for (int bst = 0; bst < 6; bst++) begin
            for (int j = 0; j < 8; j++) begin
                tx_write = 1'b1;
                tx_byte = 8'((bst * 8 + j) * 37 + 11);
                exp.push_back(tx_byte);
                step();
            end
            tx_write = 1'b0;
            repeat (792) step();
        end
        wait_idle(1500, "t6_idle");
        check_rx(exp, 1'b0, "t6_rx");
        chk("t6_no_ovf", ovf_cnt - ovf0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
